// File: rtl/gobang_buzzer.sv
// gobang_buzzer: tone sequencer for the Gobang board buzzer.
// A move plays one chirp note. A win plays a four-note melody (A, B, A, B).
// buz is active-low (1 = silent). busy is high while a sound is playing.
// Optional feature: define GOBANG_BUZZER_MUTE_EN to add a mute input.
// mute forces buz silent without affecting the sequencer or busy.
module gobang_buzzer #(
    parameter int HALF_MOVE   = 25000,
    parameter int HALF_A      = 19000,
    parameter int HALF_B      = 12500,
    parameter int NOTE_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic play_move,
    input  logic play_win,
`ifdef GOBANG_BUZZER_MUTE_EN
    input  logic mute,
`endif
    output logic buz,
    output logic busy
);

    localparam int HALF_MAX_AB = (HALF_A > HALF_B) ? HALF_A : HALF_B;
    localparam int HALF_MAX    = (HALF_MOVE > HALF_MAX_AB) ? HALF_MOVE : HALF_MAX_AB;
    localparam int TW          = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int NW          = $clog2(NOTE_CYCLES);

    localparam logic [NW-1:0] NOTE_LAST      = NW'(NOTE_CYCLES - 1);
    localparam logic [TW-1:0] HALF_MOVE_LAST = TW'(HALF_MOVE - 1);
    localparam logic [TW-1:0] HALF_A_LAST    = TW'(HALF_A - 1);
    localparam logic [TW-1:0] HALF_B_LAST    = TW'(HALF_B - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MOVE = 3'd1;
    localparam logic [2:0] S_WIN0 = 3'd2;
    localparam logic [2:0] S_WIN1 = 3'd3;
    localparam logic [2:0] S_WIN2 = 3'd4;
    localparam logic [2:0] S_WIN3 = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [NW-1:0] note_cnt_q, note_cnt_d;
    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          buz_q, buz_d;
    logic          busy_q, busy_d;

    // Terminal tone-counter value (half-period minus one) for the note of a state.
    function automatic logic [TW-1:0] half_last(input logic [2:0] st);
        logic [TW-1:0] r;
        case (st)
            S_MOVE:         r = HALF_MOVE_LAST;
            S_WIN0, S_WIN2: r = HALF_A_LAST;
            S_WIN1, S_WIN3: r = HALF_B_LAST;
            default:        r = HALF_MOVE_LAST;
        endcase
        return r;
    endfunction

    // Next-state logic: triggers first (win beats move), then note sequencing and tone toggling.
    always_comb begin
        state_d    = state_q;
        note_cnt_d = note_cnt_q;
        tone_cnt_d = tone_cnt_q;
        buz_d      = buz_q;
        busy_d     = busy_q;
        if (play_win) begin
            state_d    = S_WIN0;
            note_cnt_d = '0;
            tone_cnt_d = '0;
            buz_d      = 1'b0;
            busy_d     = 1'b1;
        end else if (play_move && ((state_q == S_IDLE) || (state_q == S_MOVE))) begin
            state_d    = S_MOVE;
            note_cnt_d = '0;
            tone_cnt_d = '0;
            buz_d      = 1'b0;
            busy_d     = 1'b1;
        end else if (state_q == S_IDLE) begin
            note_cnt_d = '0;
            tone_cnt_d = '0;
            buz_d      = 1'b1;
            busy_d     = 1'b0;
        end else if (note_cnt_q == NOTE_LAST) begin
            // Note boundary: next note starts low with a cleared tone counter.
            note_cnt_d = '0;
            tone_cnt_d = '0;
            case (state_q)
                S_WIN0: begin
                    state_d = S_WIN1;
                    buz_d   = 1'b0;
                    busy_d  = 1'b1;
                end
                S_WIN1: begin
                    state_d = S_WIN2;
                    buz_d   = 1'b0;
                    busy_d  = 1'b1;
                end
                S_WIN2: begin
                    state_d = S_WIN3;
                    buz_d   = 1'b0;
                    busy_d  = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    buz_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end else begin
            note_cnt_d = note_cnt_q + NW'(1);
            busy_d     = 1'b1;
            if (tone_cnt_q == half_last(state_q)) begin
                tone_cnt_d = '0;
                buz_d      = ~buz_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TW'(1);
                buz_d      = buz_q;
            end
        end
    end

    // State registers; reset silences the buzzer immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            note_cnt_q <= '0;
            tone_cnt_q <= '0;
            buz_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_cnt_q <= note_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            buz_q      <= buz_d;
            busy_q     <= busy_d;
        end
    end

`ifdef GOBANG_BUZZER_MUTE_EN
    assign buz = buz_q | mute;
`else
    assign buz = buz_q;
`endif
    assign busy = busy_q;

endmodule

// File: tb/tb_gobang_buzzer.sv
// tb_gobang_buzzer: directed and random stimulus checked against a
// time-based model of the buzzer (elapsed cycles -> note -> tone phase).
module tb_gobang_buzzer;

    localparam int HM = 2;
    localparam int HA = 3;
    localparam int HB = 5;
    localparam int NC = 20;

    logic clk;
    logic rst;
    logic play_move;
    logic play_win;
    logic mute;
    logic buz;
    logic busy;

    int n_vec;
    int n_err;

    // Reference model state: a sound is active, its kind, and cycles since its start.
    bit m_active;
    bit m_win;
    int m_elapsed;

    gobang_buzzer #(
        .HALF_MOVE  (HM),
        .HALF_A     (HA),
        .HALF_B     (HB),
        .NOTE_CYCLES(NC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .play_move(play_move),
        .play_win (play_win),
`ifdef GOBANG_BUZZER_MUTE_EN
        .mute     (mute),
`endif
        .buz      (buz),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_buz();
        int note;
        int off;
        int half;
        if (mute) return 1'b1;
        if (!m_active) return 1'b1;
        note = m_elapsed / NC;
        off  = m_elapsed % NC;
        if (m_win) half = ((note % 2) == 0) ? HA : HB;
        else       half = HM;
        return (((off / half) % 2) != 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic model_edge(input bit pm, input bit pw);
        if (pw) begin
            m_active  = 1'b1;
            m_win     = 1'b1;
            m_elapsed = 0;
        end else if (pm && !(m_active && m_win)) begin
            m_active  = 1'b1;
            m_win     = 1'b0;
            m_elapsed = 0;
        end else if (m_active) begin
            m_elapsed++;
            if (m_elapsed >= (m_win ? 4 * NC : NC)) m_active = 1'b0;
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".buz"}, {31'd0, buz}, {31'd0, exp_buz()});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_active});
    endtask

    // One clock with the given trigger levels, then check 1 time unit after the edge.
    task automatic cycle(input bit pm, input bit pw, input string tag);
        play_move = pm;
        play_win  = pw;
        @(posedge clk);
        model_edge(pm, pw);
        #1;
        check_out(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, tag);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_active  = 1'b0;
        m_win     = 1'b0;
        m_elapsed = 0;
        mute      = 1'b0;
        play_move = 1'b0;
        play_win  = 1'b0;
        rst       = 1'b0;
        #12;
        check_out("reset");
        @(negedge clk);
        rst = 1'b1;

        idle_cycles(100, "idle");

        cycle(1'b1, 1'b0, "move");
        idle_cycles(24, "move");

        cycle(1'b0, 1'b1, "win");
        idle_cycles(84, "win");

        cycle(1'b1, 1'b1, "collide");
        idle_cycles(29, "collide");
        cycle(1'b1, 1'b0, "collide_mv");
        idle_cycles(55, "collide");

        cycle(1'b1, 1'b0, "abort");
        idle_cycles(6, "abort");
        cycle(1'b0, 1'b1, "abort_win");
        idle_cycles(44, "abort");
        #2;
        rst = 1'b0;
        m_active = 1'b0;
        #1;
        check_out("async_rst");
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(20, "post_rst");

        cycle(1'b1, 1'b0, "restart_mv");
        idle_cycles(5, "restart_mv");
        cycle(1'b1, 1'b0, "restart_mv");
        cycle(1'b1, 1'b0, "held_mv");
        cycle(1'b1, 1'b0, "held_mv");
        idle_cycles(22, "restart_mv");

`ifdef GOBANG_BUZZER_MUTE_EN
        mute = 1'b1;
        cycle(1'b0, 1'b1, "mute");
        idle_cycles(49, "mute");
        #2;
        mute = 1'b0;
        #1;
        check_out("unmute_comb");
        idle_cycles(35, "unmute");
`endif

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 14) == 0), ($urandom_range(0, 59) == 0), "rand");
        end
        idle_cycles(90, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
